// File: rtl/rnd_pkg.sv
// Shared constants and helpers for the random-word pool.
// Combinational only; no latency and no flow control.
package rnd_pkg;
   localparam int ROT_AMT   = 16;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_FOLD  = 2;

   function automatic logic [31:0] rot16(input logic [31:0] x);
      return {x[ROT_AMT-1:0], x[31:ROT_AMT]};
   endfunction
endpackage

// File: rtl/rnd_fifo.sv
// Sync FIFO with registered head: a push into an empty FIFO is visible one edge later.
// Push must only be asserted when not full or popping in the same cycle; clr wins over both.
module rnd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       push_vld,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop_rdy,
   output logic                       head_vld,
   output logic [W-1:0]               head_dat,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
   logic [LW-1:0] kept, lvl_nxt;
   logic [W-1:0]  head_nxt;
   logic          pop;

   assign pop     = head_vld & pop_rdy;
   assign rd_nxt  = rd_ptr + AW'(pop);
   assign kept    = level - LW'(pop);
   assign lvl_nxt = kept + LW'(push_vld);

   // The next head comes from memory if older entries survive the pop,
   // otherwise straight from the word being pushed this cycle.
   always_comb begin
      head_nxt = '0;
      if (kept != '0)
         head_nxt = mem[rd_nxt];
      else if (push_vld)
         head_nxt = push_dat;
   end

   always_ff @(posedge clk) begin
      if (push_vld && !clr)
         mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         head_vld <= 1'b0;
         head_dat <= '0;
      end else begin
         rd_ptr   <= rd_nxt;
         wr_ptr   <= wr_ptr + AW'(push_vld);
         level    <= lvl_nxt;
         head_vld <= (lvl_nxt != '0);
         head_dat <= head_nxt;
      end
   end
endmodule

// File: rtl/rnd_pool.sv
// Folds FOLD raw LFSR words per entry into a DEPTH-deep pool; first entry visible after FOLD edges.
// Harvesting stalls while the pool is full and unread; flush drops the pool and any partial fold.
module rnd_pool
   import rnd_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int FOLD  = DEF_FOLD
) (
   input  logic                       clk,
   input  logic                       I_reset,
   input  logic [31:0]                I_rnd,
   input  logic                       I_flush,
   input  logic                       I_ready,
   output logic                       O_valid,
   output logic [31:0]                O_data,
   output logic [$clog2(DEPTH):0]     O_level
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int FW = (FOLD > 1) ? $clog2(FOLD) : 1;

   logic [FW-1:0] fcnt;
   logic [31:0]   acc, term, fold_val;
   logic          last, pop, he, push;

   assign last     = (fcnt == FW'(FOLD - 1));
   assign pop      = O_valid & I_ready;
   assign he       = (O_level < LW'(DEPTH)) | pop;
   assign term     = fcnt[0] ? rot16(I_rnd) : I_rnd;
   assign fold_val = (fcnt == '0) ? I_rnd : (acc ^ term);
   assign push     = he & last & ~I_flush & ~I_reset;

   // acc survives a flush on purpose; fcnt=0 makes the stale value unused.
   always_ff @(posedge clk) begin
      if (I_reset) begin
         acc  <= '0;
         fcnt <= '0;
      end else if (I_flush) begin
         fcnt <= '0;
      end else if (he) begin
         acc  <= fold_val;
         fcnt <= last ? '0 : fcnt + FW'(1);
      end
   end

   rnd_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk      (clk),
      .clr      (I_reset | I_flush),
      .push_vld (push),
      .push_dat (fold_val),
      .pop_rdy  (I_ready),
      .head_vld (O_valid),
      .head_dat (O_data),
      .level    (O_level)
   );
endmodule

// File: tb/tb_rnd_pool.sv
module tb_rnd_pool;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, flush_a, ready_a;
   logic [31:0] rnd_a;
   logic        valid_a;
   logic [31:0] data_a;
   logic [2:0]  level_a;

   logic        rst_b, flush_b, ready_b;
   logic [31:0] rnd_b;
   logic        valid_b;
   logic [31:0] data_b;
   logic [2:0]  level_b;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] q_m[$];
   int          m_fcnt;
   logic [31:0] m_acc;

   rnd_pool #(.DEPTH(4), .FOLD(2)) dut_a (
      .clk(clk), .I_reset(rst_a), .I_rnd(rnd_a), .I_flush(flush_a), .I_ready(ready_a),
      .O_valid(valid_a), .O_data(data_a), .O_level(level_a));

   rnd_pool #(.DEPTH(4), .FOLD(1)) dut_b (
      .clk(clk), .I_reset(rst_b), .I_rnd(rnd_b), .I_flush(flush_b), .I_ready(ready_b),
      .O_valid(valid_b), .O_data(data_b), .O_level(level_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input int l);
      chk({tag, "_vld_a"}, 32'(valid_a), 32'(v));
      chk({tag, "_dat_a"}, data_a, d);
      chk({tag, "_lvl_a"}, 32'(level_a), 32'(l));
   endtask

   task automatic chk_b(input string tag, input logic v, input logic [31:0] d, input int l);
      chk({tag, "_vld_b"}, 32'(valid_b), 32'(v));
      chk({tag, "_dat_b"}, data_b, d);
      chk({tag, "_lvl_b"}, 32'(level_b), 32'(l));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_a(input logic [31:0] r);
      rnd_a = r;
      tick();
   endtask

   // Reference model for instance A, advanced once per edge from the current inputs.
   task automatic model_step;
      bit          pop;
      logic [31:0] t, v;
      pop = (q_m.size() != 0) && ready_a;
      if (rst_a) begin
         q_m.delete(); m_fcnt = 0; m_acc = '0;
      end else if (flush_a) begin
         q_m.delete(); m_fcnt = 0;
      end else if (q_m.size() < 4 || pop) begin
         if (pop) void'(q_m.pop_front());
         t = (m_fcnt % 2 == 1) ? {rnd_a[15:0], rnd_a[31:16]} : rnd_a;
         v = (m_fcnt == 0) ? rnd_a : (m_acc ^ t);
         if (m_fcnt == 1) begin
            q_m.push_back(v); m_fcnt = 0;
         end else begin
            m_acc = v; m_fcnt++;
         end
      end
   endtask

   initial begin
      logic [31:0] eh;
      rst_a = 1'b1; flush_a = 1'b0; ready_a = 1'b0; rnd_a = '0;
      rst_b = 1'b1; flush_b = 1'b0; ready_b = 1'b0; rnd_b = '0;
      tick();
      tick();
      chk_a("reset", 1'b0, 32'h0, 0);
      chk_b("reset", 1'b0, 32'h0, 0);

      // Fill A with four hand-computed entries while the consumer is stalled.
      rst_a = 1'b0;
      feed_a(32'h12345678); chk_a("fold_half", 1'b0, 32'h0, 0);
      feed_a(32'h0000FFFF); chk_a("entry1", 1'b1, 32'hEDCB5678, 1);
      feed_a(32'h11111111);
      feed_a(32'h00000001); chk_a("entry2", 1'b1, 32'hEDCB5678, 2);
      feed_a(32'hAAAAAAAA);
      feed_a(32'h0000FFFF); chk_a("entry3", 1'b1, 32'hEDCB5678, 3);
      feed_a(32'h00000000);
      feed_a(32'h12340000); chk_a("full", 1'b1, 32'hEDCB5678, 4);
      for (int i = 0; i < 12; i++) feed_a(32'hDEADBEEF ^ 32'(i));
      chk_a("stall", 1'b1, 32'hEDCB5678, 4);

      // One pop from full: fcnt was frozen at 0, so the harvest after it starts a new fold.
      ready_a = 1'b1;
      feed_a(32'h0F0F0F0F); chk_a("pop_full", 1'b1, 32'h11101111, 3);
      ready_a = 1'b0;
      feed_a(32'h000000F0); chk_a("refill", 1'b1, 32'h11101111, 4);
      ready_a = 1'b1;
      feed_a(32'h00000000); chk_a("pop2", 1'b1, 32'h5555AAAA, 3);

      // Flush with a coinciding pop at level 3, then refill from fcnt=0.
      flush_a = 1'b1;
      feed_a(32'h77777777); chk_a("flush", 1'b0, 32'h0, 0);
      flush_a = 1'b0; ready_a = 1'b0;
      feed_a(32'h12345678); chk_a("post_flush_half", 1'b0, 32'h0, 0);
      feed_a(32'h0000FFFF); chk_a("post_flush", 1'b1, 32'hEDCB5678, 1);

      // Reset mid-fold drops the partial entry.
      feed_a(32'h55555555); chk_a("mid_fold", 1'b1, 32'hEDCB5678, 1);
      rst_a = 1'b1;
      feed_a(32'h66666666); chk_a("mid_reset", 1'b0, 32'h0, 0);
      rst_a = 1'b0;
      feed_a(32'h12345678); chk_a("post_reset_half", 1'b0, 32'h0, 0);
      feed_a(32'h0000FFFF); chk_a("post_reset", 1'b1, 32'hEDCB5678, 1);

      // FOLD=1: fill to full, then push and pop on the same edge.
      rst_b = 1'b0;
      rnd_b = 32'hA0000001; tick(); chk_b("f1_first", 1'b1, 32'hA0000001, 1);
      rnd_b = 32'hA0000002; tick();
      rnd_b = 32'hA0000003; tick();
      rnd_b = 32'hA0000004; tick(); chk_b("f1_full", 1'b1, 32'hA0000001, 4);
      rnd_b = 32'hFFFFFFFF; tick(); tick(); tick();
      chk_b("f1_stall", 1'b1, 32'hA0000001, 4);
      ready_b = 1'b1;
      rnd_b = 32'hA0000005; tick(); chk_b("f1_pushpop", 1'b1, 32'hA0000002, 4);
      ready_b = 1'b0; flush_b = 1'b1;
      tick(); chk_b("f1_flush", 1'b0, 32'h0, 0);
      flush_b = 1'b0; ready_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rnd_b = 32'h10000000 + 32'(i) * 32'h01010101;
         tick();
         chk_b("f1_stream", 1'b1, rnd_b, 1);
      end

      // Random traffic on A against the reference model.
      for (int i = 0; i < 10000; i++) begin
         rst_a   = (i == 0) || ($urandom_range(0, 199) == 0);
         flush_a = ($urandom_range(0, 49) == 0);
         ready_a = $urandom_range(0, 1) == 1;
         rnd_a   = $urandom;
         model_step();
         tick();
         eh = (q_m.size() != 0) ? q_m[0] : 32'h0;
         chk_a("rand", q_m.size() != 0, eh, q_m.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
